// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between an instruction-fetch port (I)
// and a data load/store port (D); each access runs IDLE -> ISSUE -> [WAIT] -> DONE.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  // Handshake: a requester holds req high until its one-cycle ack; address, we
  // and wdata are latched at grant, so changes after grant have no effect.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state, state_nx;
  logic                  gnt_d, gnt_d_nx;
  logic                  last_d, last_d_nx;
  logic                  we_q, we_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  m_en_nx, m_we_nx, i_ack_nx, d_ack_nx;
  logic [ADDR_WIDTH-1:0] m_addr_nx;
  logic [DATA_WIDTH-1:0] m_wdata_nx, i_rdata_nx, d_rdata_nx;
  logic                  i_elig, d_elig, pick_d;

  // The port being acked in DONE is not eligible again in that same cycle.
  assign i_elig    = i_req && !(state == DONE && !gnt_d);
  assign d_elig    = d_req && !(state == DONE && gnt_d);
  assign pick_d    = d_elig && (!i_elig || !last_d);
  assign fsm_state = state;

  always_comb begin
    state_nx   = state;
    gnt_d_nx   = gnt_d;
    last_d_nx  = last_d;
    we_nx      = we_q;
    cnt_nx     = cnt;
    m_en_nx    = 1'b0;
    m_we_nx    = 1'b0;
    m_addr_nx  = m_addr;
    m_wdata_nx = m_wdata;
    i_ack_nx   = 1'b0;
    d_ack_nx   = 1'b0;
    i_rdata_nx = i_rdata;
    d_rdata_nx = d_rdata;
    case (state)
      IDLE, DONE: begin
        if (i_elig || d_elig) begin
          state_nx = ISSUE;
          gnt_d_nx = pick_d;
          we_nx    = pick_d && d_we;
          m_en_nx  = 1'b1;
          m_we_nx  = pick_d && d_we;
          m_addr_nx = pick_d ? d_addr : i_addr;
          if (pick_d) m_wdata_nx = d_wdata;
          if (i_elig && d_elig) last_d_nx = pick_d;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_nx = DONE;
          if (gnt_d) d_ack_nx = 1'b1;
          else       i_ack_nx = 1'b1;
        end else begin
          state_nx = WAIT;
          cnt_nx   = 4'(MEM_LATENCY);
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nx = DONE;
          if (gnt_d) begin
            d_ack_nx   = 1'b1;
            d_rdata_nx = m_rdata;
          end else begin
            i_ack_nx   = 1'b1;
            i_rdata_nx = m_rdata;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt_d   <= 1'b0;
      last_d  <= 1'b1;
      we_q    <= 1'b0;
      cnt     <= 4'd0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      gnt_d   <= gnt_d_nx;
      last_d  <= last_d_nx;
      we_q    <= we_nx;
      cnt     <= cnt_nx;
      m_en    <= m_en_nx;
      m_we    <= m_we_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      i_ack   <= i_ack_nx;
      d_ack   <= d_ack_nx;
      i_rdata <= i_rdata_nx;
      d_rdata <= d_rdata_nx;
      busy    <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 3) driven in parallel,
// each checked every cycle against a transaction-timeline model plus literal checks.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic          i_req   [NI];
  logic [AW-1:0] i_addr  [NI];
  logic [DW-1:0] i_rdata [NI];
  logic          i_ack   [NI];
  logic          d_req   [NI];
  logic          d_we    [NI];
  logic [AW-1:0] d_addr  [NI];
  logic [DW-1:0] d_wdata [NI];
  logic [DW-1:0] d_rdata [NI];
  logic          d_ack   [NI];
  logic          m_en    [NI];
  logic          m_we    [NI];
  logic [AW-1:0] m_addr  [NI];
  logic [DW-1:0] m_wdata [NI];
  logic [DW-1:0] m_rdata [NI];
  logic          busy    [NI];
  logic [1:0]    fsm_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clock(clock), .reset(reset),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_ack(i_ack[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g]), .busy(busy[g]), .fsm_state(fsm_state[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, k, cyc, got, exp);
    end
  endtask

  task automatic chk1(input string name, input int k, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cycle %0d: got %b, expected %b", name, k, cyc, got, exp);
    end
  endtask

  // ---------------- memory behind each instance ----------------
  logic [DW-1:0] mem     [NI][256];
  logic [DW-1:0] ref_mem [NI][256];
  logic          hv      [NI][16];
  logic [DW-1:0] hd      [NI][16];

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_rdata[k] = '0;
      for (int j = 0; j < 16; j++) begin
        hv[k][j] = 1'b0;
        hd[k][j] = '0;
      end
    end
    forever begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) begin
        if (reset) begin
          for (int j = 0; j < 16; j++) hv[k][j] = 1'b0;
        end else begin
          for (int j = 15; j > 0; j--) begin
            hv[k][j] = hv[k][j-1];
            hd[k][j] = hd[k][j-1];
          end
          hv[k][0] = m_en[k] && !m_we[k];
          hd[k][0] = mem[k][m_addr[k][7:0]];
          if (m_en[k] && m_we[k]) mem[k][m_addr[k][7:0]] = m_wdata[k];
        end
        // Read data is only correct in the one cycle it is valid.
        m_rdata[k] = hv[k][lat_of(k)] ? hd[k][lat_of(k)]
                                      : (32'hA5A5_0000 | 32'($urandom_range(0, 65535)));
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic          act    [NI];
  int            age    [NI];
  int            a_port [NI];
  logic          a_we   [NI];
  logic [AW-1:0] a_addr [NI];
  logic [DW-1:0] a_wd   [NI];
  logic [DW-1:0] a_rd   [NI];
  int            last_p [NI];
  logic          e_m_en [NI], e_m_we [NI], e_i_ack [NI], e_d_ack [NI], e_busy [NI];
  logic [AW-1:0] e_m_addr [NI];
  logic [DW-1:0] e_m_wdata [NI], e_i_rdata [NI], e_d_rdata [NI];

  task automatic model_reset(input int k);
    act[k] = 1'b0; age[k] = 0; a_port[k] = 0; a_we[k] = 1'b0;
    a_addr[k] = '0; a_wd[k] = '0; a_rd[k] = '0; last_p[k] = 1;
    e_m_en[k] = 1'b0; e_m_we[k] = 1'b0; e_i_ack[k] = 1'b0; e_d_ack[k] = 1'b0;
    e_busy[k] = 1'b0; e_m_addr[k] = '0; e_m_wdata[k] = '0;
    e_i_rdata[k] = '0; e_d_rdata[k] = '0;
  endtask

  // An access granted at an edge issues one cycle later and acks at age 2 (write)
  // or 2+latency (read); the ack cycle is also an arbitration point.
  task automatic model_step(input int k);
    int   ack_age, excl, gp;
    logic free, ei, ed;
    ack_age = a_we[k] ? 2 : 2 + lat_of(k);
    free = 1'b0;
    excl = -1;
    if (!act[k]) free = 1'b1;
    else if (age[k] == ack_age) begin
      free = 1'b1;
      excl = a_port[k];
    end
    if (free) begin
      ei = i_req[k] && excl != 0;
      ed = d_req[k] && excl != 1;
      gp = -1;
      if (ei && ed) begin
        gp = (last_p[k] == 1) ? 0 : 1;
        last_p[k] = gp;
      end else if (ei) gp = 0;
      else if (ed) gp = 1;
      act[k] = (gp >= 0);
      if (gp >= 0) begin
        age[k]    = 1;
        a_port[k] = gp;
        a_we[k]   = (gp == 1) && d_we[k];
        a_addr[k] = (gp == 0) ? i_addr[k] : d_addr[k];
        a_wd[k]   = d_wdata[k];
        e_m_addr[k] = a_addr[k];
        if (a_we[k]) ref_mem[k][a_addr[k][7:0]] = a_wd[k];
        else         a_rd[k] = ref_mem[k][a_addr[k][7:0]];
      end
    end else begin
      age[k]++;
    end
    ack_age      = a_we[k] ? 2 : 2 + lat_of(k);
    e_m_en[k]    = act[k] && age[k] == 1;
    e_m_we[k]    = e_m_en[k] && a_we[k];
    e_m_wdata[k] = a_wd[k];
    e_i_ack[k]   = act[k] && age[k] == ack_age && a_port[k] == 0;
    e_d_ack[k]   = act[k] && age[k] == ack_age && a_port[k] == 1;
    if (e_i_ack[k] && !a_we[k]) e_i_rdata[k] = a_rd[k];
    if (e_d_ack[k] && !a_we[k]) e_d_rdata[k] = a_rd[k];
    e_busy[k] = act[k];
  endtask

  initial begin
    for (int k = 0; k < NI; k++) model_reset(k);
    forever begin
      @(posedge clock or posedge reset);
      for (int k = 0; k < NI; k++) begin
        if (reset) model_reset(k);
        else       model_step(k);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      chk1("m_en", k, m_en[k], e_m_en[k]);
      chk1("m_we", k, m_we[k], e_m_we[k]);
      chk("m_addr", k, m_addr[k], e_m_addr[k]);
      if (e_m_we[k]) chk("m_wdata", k, m_wdata[k], e_m_wdata[k]);
      chk1("i_ack", k, i_ack[k], e_i_ack[k]);
      chk1("d_ack", k, d_ack[k], e_d_ack[k]);
      chk1("busy", k, busy[k], e_busy[k]);
      chk("i_rdata", k, i_rdata[k], e_i_rdata[k]);
      chk("d_rdata", k, d_rdata[k], e_d_rdata[k]);
    end
  end

  // ---------------- ack-order monitor ----------------
  bit alt_on = 1'b0;
  int mon_last [NI];
  int mon_rep  [NI];
  int mon_acks [NI];
  initial forever begin
    @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      if (alt_on && (i_ack[k] || d_ack[k])) begin
        if (mon_last[k] == int'(d_ack[k])) mon_rep[k]++;
        mon_last[k] = int'(d_ack[k]);
        mon_acks[k]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_txn(input int k, input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold, input bit scramble,
                        output int start, output int en_cyc, output int ack_cyc,
                        output logic [31:0] en_addr, output logic [31:0] en_wdata,
                        output logic en_we, output int other_acks);
    bit done;
    start = cyc; en_cyc = -1; ack_cyc = -1; other_acks = 0;
    en_addr = '0; en_wdata = '0; en_we = 1'b0; done = 1'b0;
    if (p == 0) begin
      i_addr[k] = addr;
      i_req[k]  = 1'b1;
    end else begin
      d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
      d_req[k] = 1'b1;
    end
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clock);
      if (en_cyc < 0 && m_en[k] && !reset) begin
        en_cyc = cyc; en_addr = m_addr[k]; en_wdata = m_wdata[k]; en_we = m_we[k];
      end
      if (p == 0 ? i_ack[k] : d_ack[k]) begin
        ack_cyc = cyc;
        done = 1'b1;
      end else if (p == 0 ? d_ack[k] : i_ack[k]) begin
        other_acks++;
      end
      #1;
      if (scramble && en_cyc >= 0 && !done) begin
        if (p == 0) i_addr[k] = $urandom();
        else begin
          d_addr[k] = $urandom(); d_wdata[k] = $urandom();
          d_we[k] = 1'($urandom_range(0, 1));
        end
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL ack_timeout inst%0d port%0d: no ack within 80 cycles", k, p);
    end
    if (!hold || !done) begin
      if (p == 0) i_req[k] = 1'b0;
      else        d_req[k] = 1'b0;
    end
  endtask

  task automatic test_solo(input int k, input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd, input int exp_ack);
    int s, e, a, o;
    logic [31:0] ea, ew;
    logic eww;
    do_txn(k, p, we, addr, wdata, 1'b0, 1'b1, s, e, a, ea, ew, eww, o);
    chk("en_delay", k, 32'(e - s), 32'd1);
    chk("ack_delay", k, 32'(a - s), 32'(exp_ack));
    chk("en_addr", k, ea, addr);
    chk1("en_we", k, eww, we);
    chk("other_acks", k, 32'(o), 32'd0);
    if (we) chk("en_wdata", k, ew, wdata);
    else    chk("rdata", k, (p == 0) ? i_rdata[k] : d_rdata[k], exp_rd);
  endtask

  int t1_ack [NI][2];
  task automatic t1_branch(input int k, input int p);
    int s, e, a, o;
    logic [31:0] ea, ew;
    logic eww;
    do_txn(k, p, 1'b0, (p == 0) ? 32'h04 : 32'h08, 32'h0, 1'b0, 1'b0, s, e, a, ea, ew, eww, o);
    t1_ack[k][p] = a;
  endtask

  task automatic stream(input int k, input int p);
    int s, e, a, o;
    logic [31:0] ea, ew;
    logic eww;
    for (int i = 0; i < 3; i++)
      do_txn(k, p, (p == 1) && (i != 1), ((p == 0) ? 32'h40 : 32'h30) + 32'(i),
             32'h11 * 32'(i + 1), i < 2, 1'b0, s, e, a, ea, ew, eww, o);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_ack [NI];
    for (int k = 0; k < NI; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0;
      mon_last[k] = -1; mon_rep[k] = 0; mon_acks[k] = 0;
      for (int a = 0; a < 256; a++) begin
        mem[k][a]     = 32'hC0DE_0000 | 32'(a);
        ref_mem[k][a] = 32'hC0DE_0000 | 32'(a);
      end
      mem[k][8'h10]     = 32'hDEAD_BEEF;
      ref_mem[k][8'h10] = 32'hDEAD_BEEF;
    end
    @(negedge clock); #1;

    // Reset held with both requests high, then release: I must be served first.
    fork
      t1_branch(0, 0); t1_branch(0, 1); t1_branch(1, 0); t1_branch(1, 1);
      begin
        repeat (2) begin
          @(negedge clock);
          for (int k = 0; k < NI; k++) begin
            chk1("rst_busy", k, busy[k], 1'b0);
            chk1("rst_m_en", k, m_en[k], 1'b0);
            chk1("rst_i_ack", k, i_ack[k], 1'b0);
          end
        end
        #1 reset = 1'b0;
      end
    join
    for (int k = 0; k < NI; k++) chk1("i_first", k, t1_ack[k][0] < t1_ack[k][1], 1'b1);
    idle(3);

    // Solo fetch read of 0xDEADBEEF.
    fork
      test_solo(0, 0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 3);
      test_solo(1, 0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 5);
    join
    idle(2);

    // Solo data write then read-back.
    fork
      test_solo(0, 1, 1'b1, 32'h20, 32'h5, 32'h0, 2);
      test_solo(1, 1, 1'b1, 32'h20, 32'h5, 32'h0, 2);
    join
    idle(2);
    fork
      test_solo(0, 1, 1'b0, 32'h20, 32'h0, 32'h5, 3);
      test_solo(1, 1, 1'b0, 32'h20, 32'h0, 32'h5, 5);
    join
    idle(2);

    // Both ports streaming: grants must alternate with no port acked twice in a row.
    alt_on = 1'b1;
    fork
      stream(0, 0); stream(0, 1); stream(1, 0); stream(1, 1);
    join
    alt_on = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("alt_repeats", k, 32'(mon_rep[k]), 32'd0);
      chk("alt_acks", k, 32'(mon_acks[k]), 32'd6);
    end
    idle(2);

    // Reset asserted while a read is waiting on memory: access discarded, no ack.
    for (int k = 0; k < NI; k++) begin
      i_addr[k] = 32'h10;
      i_req[k]  = 1'b1;
    end
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k < NI; k++) i_req[k] = 1'b0;
    @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      chk1("rst_wait_m_en", k, m_en[k], 1'b0);
      chk1("rst_wait_busy", k, busy[k], 1'b0);
    end
    #1 reset = 1'b0;
    for (int k = 0; k < NI; k++) n_ack[k] = 0;
    repeat (6) begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) if (i_ack[k] || d_ack[k]) n_ack[k]++;
    end
    for (int k = 0; k < NI; k++) chk("rst_wait_acks", k, 32'(n_ack[k]), 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
